// File: rtl/regfile_sb.sv
// regfile_sb: general-purpose register file with a per-register
// pending-write scoreboard and same-cycle writeback bypass.
module regfile_sb #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2,
   parameter int CNT_W  = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_RD-1:0]        rd_en,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_ready,
   input  logic                     iss_valid,
   input  logic [ADDR_W-1:0]        iss_addr,
   output logic                     iss_ok,
   input  logic                     we,
   input  logic [ADDR_W-1:0]        waddr,
   input  logic [DATA_W-1:0]        wdata,
   input  logic                     flush
);

   localparam int NREG = 2**ADDR_W;
   localparam logic [CNT_W-1:0] MAX = '1;

   logic [DATA_W-1:0] reg_array [NREG];
   logic [CNT_W-1:0]  cnt [NREG];
   logic [NREG-1:0]   inc;
   logic [NREG-1:0]   dec;
   logic              wb_hit_iss;
   logic              iss_acc;

   // A retire in the same cycle frees a slot, so a full counter can still accept.
   assign wb_hit_iss = we && (waddr == iss_addr);
   assign iss_ok = !rst && !flush &&
                   ((iss_addr == '0) || (cnt[iss_addr] != MAX) || wb_hit_iss);
   assign iss_acc = iss_valid && iss_ok && (iss_addr != '0);

   always_comb begin
      inc = '0;
      dec = '0;
      for (int r = 0; r < NREG; r++) begin
         inc[r] = iss_acc && (iss_addr == ADDR_W'(r));
         dec[r] = we && (waddr == ADDR_W'(r)) && (cnt[r] != '0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < NREG; r++) begin
            reg_array[r] <= '0;
            cnt[r]       <= '0;
         end
      end else begin
         if (we && (waddr != '0))
            reg_array[waddr] <= wdata;
         for (int r = 0; r < NREG; r++) begin
            if (flush)
               cnt[r] <= '0;
            else if (inc[r] && !dec[r])
               cnt[r] <= cnt[r] + CNT_W'(1);
            else if (dec[r] && !inc[r])
               cnt[r] <= cnt[r] - CNT_W'(1);
         end
      end
   end

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [ADDR_W-1:0] a;
      logic [CNT_W-1:0]  c;
      logic              hit;
      logic              idle;

      assign a    = rd_addr[i*ADDR_W +: ADDR_W];
      assign c    = cnt[a];
      assign hit  = we && (waddr == a);
      assign idle = !rd_en[i] || (a == '0);

      assign rd_data[i*DATA_W +: DATA_W] =
         (rst || idle) ? '0 :
         hit           ? wdata :
                         reg_array[a];

      // Final only if no write remains pending after any same-cycle retire.
      assign rd_ready[i] =
         rst  ? 1'b0 :
         idle ? 1'b1 :
                ((c == '0) || ((c == CNT_W'(1)) && hit));
   end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed scenarios plus randomized traffic checked
// against an array-based model of registers and pending-write counts.
module tb_regfile_sb;

   logic        clk;
   logic        rst;
   logic [1:0]  rd_en;
   logic [9:0]  rd_addr;
   logic [63:0] rd_data;
   logic [1:0]  rd_ready;
   logic        iss_valid;
   logic [4:0]  iss_addr;
   logic        iss_ok;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic        flush;

   int nvec = 0;
   int nerr = 0;

   logic [31:0] mreg [32];
   int          mcnt [32];

   regfile_sb dut (
      .clk(clk), .rst(rst),
      .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data(rd_data), .rd_ready(rd_ready),
      .iss_valid(iss_valid), .iss_addr(iss_addr),
      .iss_ok(iss_ok),
      .we(we), .waddr(waddr), .wdata(wdata),
      .flush(flush)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] m_data(int p);
      int a;
      a = int'(rd_addr[p*5 +: 5]);
      if (rst || !rd_en[p] || a == 0) return 32'h0;
      if (we && int'(waddr) == a) return wdata;
      return mreg[a];
   endfunction

   function automatic bit m_ready(int p);
      int a;
      int left;
      a = int'(rd_addr[p*5 +: 5]);
      if (rst) return 1'b0;
      if (!rd_en[p] || a == 0) return 1'b1;
      left = mcnt[a];
      if (we && int'(waddr) == a && left > 0) left--;
      return left == 0;
   endfunction

   function automatic bit m_iss_ok();
      int left;
      if (rst || flush) return 1'b0;
      if (iss_addr == 5'd0) return 1'b1;
      left = mcnt[iss_addr];
      if (we && waddr == iss_addr && left > 0) left--;
      return left < 3;
   endfunction

   task automatic m_step();
      bit acc;
      if (rst) begin
         for (int r = 0; r < 32; r++) begin
            mreg[r] = 32'h0;
            mcnt[r] = 0;
         end
         return;
      end
      acc = iss_valid && m_iss_ok();
      if (we && waddr != 5'd0) mreg[waddr] = wdata;
      if (flush) begin
         for (int r = 0; r < 32; r++) mcnt[r] = 0;
         return;
      end
      if (we && mcnt[waddr] > 0) mcnt[waddr]--;
      if (acc && iss_addr != 5'd0) mcnt[iss_addr]++;
   endtask

   task automatic cyc();
      m_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      we = 1'b0;
      iss_valid = 1'b0;
      flush = 1'b0;
      rd_en = 2'b00;
   endtask

   task automatic set_rd(int p, bit en, logic [4:0] a);
      rd_en[p] = en;
      rd_addr[p*5 +: 5] = a;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      rd_en = 2'b11;
      rd_addr = 10'b00011_00101;
      iss_valid = 1'b1;
      iss_addr = 5'd4;
      we = 1'b1;
      waddr = 5'd3;
      wdata = 32'hA5A5_0001;
      #1;
      nvec++;
      if (rd_data !== 64'h0) begin
         nerr++;
         $display("FAIL rst_data got %h want 0", rd_data);
      end
      nvec++;
      if (rd_ready !== 2'b00) begin
         nerr++;
         $display("FAIL rst_ready got %b want 00", rd_ready);
      end
      nvec++;
      if (iss_ok !== 1'b0) begin
         nerr++;
         $display("FAIL rst_iss_ok got %b want 0", iss_ok);
      end
      cyc();
      cyc();
      rst = 1'b0;
      idle_in();
      for (int r = 1; r < 32; r++) begin
         set_rd(0, 1'b1, 5'(r));
         set_rd(1, 1'b1, 5'(r));
         #1;
         nvec++;
         if (rd_data !== 64'h0 || rd_ready !== 2'b11) begin
            nerr++;
            $display("FAIL post_rst r%0d got %h/%b want 0/11",
                     r, rd_data, rd_ready);
         end
         cyc();
      end
   endtask

   task automatic test_bypass();
      idle_in();
      we = 1'b1;
      waddr = 5'd5;
      wdata = 32'hDEAD_BEEF;
      set_rd(0, 1'b1, 5'd5);
      #1;
      nvec++;
      if (rd_data[31:0] !== 32'hDEAD_BEEF || rd_ready[0] !== 1'b1) begin
         nerr++;
         $display("FAIL bypass got %h/%b want deadbeef/1",
                  rd_data[31:0], rd_ready[0]);
      end
      cyc();
      we = 1'b0;
      #1;
      nvec++;
      if (rd_data[31:0] !== 32'hDEAD_BEEF || rd_ready[0] !== 1'b1) begin
         nerr++;
         $display("FAIL stored got %h/%b want deadbeef/1",
                  rd_data[31:0], rd_ready[0]);
      end
      cyc();
   endtask

   task automatic test_scoreboard();
      idle_in();
      iss_valid = 1'b1;
      iss_addr = 5'd7;
      #1;
      nvec++;
      if (iss_ok !== 1'b1) begin
         nerr++;
         $display("FAIL iss7 iss_ok got %b want 1", iss_ok);
      end
      cyc();
      iss_valid = 1'b0;
      set_rd(0, 1'b1, 5'd7);
      #1;
      nvec++;
      if (rd_ready[0] !== 1'b0) begin
         nerr++;
         $display("FAIL pend7 ready got %b want 0", rd_ready[0]);
      end
      iss_valid = 1'b1;
      cyc();
      iss_valid = 1'b0;
      we = 1'b1;
      waddr = 5'd7;
      wdata = 32'h11;
      #1;
      nvec++;
      if (rd_data[31:0] !== 32'h11 || rd_ready[0] !== 1'b0) begin
         nerr++;
         $display("FAIL wb1 got %h/%b want 11/0",
                  rd_data[31:0], rd_ready[0]);
      end
      cyc();
      wdata = 32'h22;
      #1;
      nvec++;
      if (rd_data[31:0] !== 32'h22 || rd_ready[0] !== 1'b1) begin
         nerr++;
         $display("FAIL wb2 got %h/%b want 22/1",
                  rd_data[31:0], rd_ready[0]);
      end
      cyc();
      we = 1'b0;
      #1;
      nvec++;
      if (rd_data[31:0] !== 32'h22 || rd_ready[0] !== 1'b1) begin
         nerr++;
         $display("FAIL drained7 got %h/%b want 22/1",
                  rd_data[31:0], rd_ready[0]);
      end
      cyc();
   endtask

   task automatic test_saturate();
      idle_in();
      iss_valid = 1'b1;
      iss_addr = 5'd3;
      for (int k = 0; k < 3; k++) begin
         #1;
         nvec++;
         if (iss_ok !== 1'b1) begin
            nerr++;
            $display("FAIL sat_iss%0d got %b want 1", k, iss_ok);
         end
         cyc();
      end
      #1;
      nvec++;
      if (iss_ok !== 1'b0) begin
         nerr++;
         $display("FAIL sat_full got %b want 0", iss_ok);
      end
      we = 1'b1;
      waddr = 5'd3;
      wdata = 32'h333;
      #1;
      nvec++;
      if (iss_ok !== 1'b1) begin
         nerr++;
         $display("FAIL sat_retire got %b want 1", iss_ok);
      end
      cyc();
      we = 1'b0;
      #1;
      nvec++;
      if (iss_ok !== 1'b0) begin
         nerr++;
         $display("FAIL sat_hold got %b want 0", iss_ok);
      end
      iss_valid = 1'b0;
      we = 1'b1;
      set_rd(1, 1'b1, 5'd3);
      for (int k = 0; k < 3; k++) begin
         wdata = 32'h300 + 32'(k);
         #1;
         nvec++;
         if (rd_ready[1] !== (k == 2)) begin
            nerr++;
            $display("FAIL sat_drain%0d got %b want %b",
                     k, rd_ready[1], k == 2);
         end
         cyc();
      end
      we = 1'b0;
   endtask

   task automatic test_flush();
      idle_in();
      iss_valid = 1'b1;
      iss_addr = 5'd9;
      cyc();
      iss_addr = 5'd10;
      cyc();
      flush = 1'b1;
      iss_addr = 5'd11;
      #1;
      nvec++;
      if (iss_ok !== 1'b0) begin
         nerr++;
         $display("FAIL flush_iss_ok got %b want 0", iss_ok);
      end
      cyc();
      idle_in();
      set_rd(0, 1'b1, 5'd9);
      set_rd(1, 1'b1, 5'd10);
      #1;
      nvec++;
      if (rd_ready !== 2'b11) begin
         nerr++;
         $display("FAIL flush_9_10 got %b want 11", rd_ready);
      end
      set_rd(0, 1'b1, 5'd11);
      #1;
      nvec++;
      if (rd_ready[0] !== 1'b1) begin
         nerr++;
         $display("FAIL flush_11 got %b want 1", rd_ready[0]);
      end
      we = 1'b1;
      waddr = 5'd9;
      wdata = 32'h5;
      cyc();
      we = 1'b0;
      set_rd(0, 1'b1, 5'd9);
      #1;
      nvec++;
      if (rd_data[31:0] !== 32'h5 || rd_ready[0] !== 1'b1) begin
         nerr++;
         $display("FAIL stray got %h/%b want 5/1",
                  rd_data[31:0], rd_ready[0]);
      end
      cyc();
   endtask

   task automatic test_zero();
      idle_in();
      we = 1'b1;
      waddr = 5'd0;
      wdata = 32'hFFFF_FFFF;
      iss_valid = 1'b1;
      iss_addr = 5'd0;
      set_rd(0, 1'b1, 5'd0);
      set_rd(1, 1'b1, 5'd0);
      #1;
      nvec++;
      if (rd_data !== 64'h0 || rd_ready !== 2'b11 || iss_ok !== 1'b1) begin
         nerr++;
         $display("FAIL zero_wr got %h/%b/%b want 0/11/1",
                  rd_data, rd_ready, iss_ok);
      end
      cyc();
      we = 1'b0;
      iss_valid = 1'b0;
      #1;
      nvec++;
      if (rd_data !== 64'h0 || rd_ready !== 2'b11) begin
         nerr++;
         $display("FAIL zero_rd got %h/%b want 0/11", rd_data, rd_ready);
      end
      cyc();
   endtask

   task automatic test_random();
      for (int n = 0; n < 600; n++) begin
         rst = ($urandom_range(0, 79) == 0);
         flush = ($urandom_range(0, 15) == 0);
         we = $urandom_range(0, 1) == 1;
         waddr = 5'($urandom_range(0, 7));
         wdata = $urandom;
         iss_valid = $urandom_range(0, 1) == 1;
         iss_addr = 5'($urandom_range(0, 7));
         rd_en = 2'($urandom_range(0, 3));
         rd_addr[4:0] = 5'($urandom_range(0, 7));
         rd_addr[9:5] = ($urandom_range(0, 3) == 0) ?
                        rd_addr[4:0] : 5'($urandom_range(0, 7));
         #1;
         for (int p = 0; p < 2; p++) begin
            nvec++;
            if (rd_data[p*32 +: 32] !== m_data(p) ||
                rd_ready[p] !== m_ready(p)) begin
               nerr++;
               $display("FAIL rnd%0d p%0d got %h/%b want %h/%b",
                        n, p, rd_data[p*32 +: 32], rd_ready[p],
                        m_data(p), m_ready(p));
            end
         end
         nvec++;
         if (iss_ok !== m_iss_ok()) begin
            nerr++;
            $display("FAIL rnd%0d iss_ok got %b want %b",
                     n, iss_ok, m_iss_ok());
         end
         cyc();
      end
      rst = 1'b0;
      idle_in();
   endtask

   initial begin
      rst = 1'b1;
      rd_en = 2'b00;
      rd_addr = '0;
      iss_valid = 1'b0;
      iss_addr = '0;
      we = 1'b0;
      waddr = '0;
      wdata = '0;
      flush = 1'b0;
      @(posedge clk);
      #1;
      test_reset();
      test_bypass();
      test_scoreboard();
      test_saturate();
      test_flush();
      test_zero();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
